// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 800x600@56 timing defaults, derived totals and shared raster types
package vga_timing_pkg;
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 72;
  localparam int H_BP_DEF     = 128;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 22;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_MAX_TOTAL  = 2048;
  localparam int V_MAX_TOTAL  = 1024;
  typedef logic [10:0] h_coord_t;
  typedef logic [9:0]  v_coord_t;
  typedef logic [3:0]  rgb4_t;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_flags_t;
  function automatic logic in_range(input int x, input int lo, input int hi);
    return (x >= lo) && (x < hi);
  endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: scan-position and colour link between the timing generator and the game plane
interface vga_timing_if;
  import vga_timing_pkg::*;
  h_coord_t h_coord;
  v_coord_t v_coord;
  logic     frame_start;
  rgb4_t    red;
  rgb4_t    green;
  rgb4_t    blue;
  modport master (output h_coord, v_coord, frame_start, input red, green, blue);
  modport slave  (input h_coord, v_coord, frame_start, output red, green, blue);
endinterface

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: parametric-depth flag shift register; depth 0 degenerates to a wire
module vga_sync_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];
    always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end
    assign q = stage[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster counters, sync/blank decode and registered VGA outputs aligned to the
// game-plane colour returned RGB_LATENCY cycles after each coordinate.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int RGB_LATENCY = 0
) (
  input  logic  pixel_clk,
  input  logic  rst_n,
  vga_timing_if.master gp,
  output rgb4_t vga_r,
  output rgb4_t vga_g,
  output rgb4_t vga_b,
  output logic  vga_hs,
  output logic  vga_vs,
  output logic  display_on
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > H_MAX_TOTAL || V_TOTAL > V_MAX_TOTAL) begin : g_bad_total
    $error("vga_timing: H_TOTAL/V_TOTAL exceed the 11/10-bit counter range");
  end
  if (RGB_LATENCY < 0 || RGB_LATENCY > 3) begin : g_bad_latency
    $error("vga_timing: RGB_LATENCY must be 0..3");
  end
  h_coord_t    h_q;
  v_coord_t    v_q;
  logic        run_q;
  logic        h_wrap;
  logic        v_wrap;
  sync_flags_t raw;
  sync_flags_t dly;
  // run_q holds the counters at (0,0) for the first edge after release so that pixel
  // (0,0) is the first coordinate issued, with frame_start high on it.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= '0;
      v_q   <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        h_q <= h_wrap ? '0 : h_q + 1'b1;
        if (h_wrap) v_q <= v_wrap ? '0 : v_q + 1'b1;
      end
    end
  end
  assign h_wrap = h_q == h_coord_t'(H_TOTAL - 1);
  assign v_wrap = v_q == v_coord_t'(V_TOTAL - 1);
  assign gp.h_coord     = h_q;
  assign gp.v_coord     = v_q;
  assign gp.frame_start = run_q && h_q == '0 && v_q == '0;
  always_comb begin
    raw.de = run_q && in_range(int'(h_q), 0, H_ACTIVE) && in_range(int'(v_q), 0, V_ACTIVE);
    raw.hs = run_q && in_range(int'(h_q), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    raw.vs = run_q && in_range(int'(v_q), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
  end
  vga_sync_delay #(
    .WIDTH    (3),
    .DEPTH    (RGB_LATENCY),
    .RESET_VAL(3'b000)
  ) u_sync_delay (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .d        (raw),
    .q        (dly)
  );
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_hs     <= ~HS_POL;
      vga_vs     <= ~VS_POL;
      display_on <= 1'b0;
    end else begin
      vga_r      <= dly.de ? gp.red : '0;
      vga_g      <= dly.de ? gp.green : '0;
      vga_b      <= dly.de ? gp.blue : '0;
      vga_hs     <= dly.hs ? HS_POL : ~HS_POL;
      vga_vs     <= dly.vs ? VS_POL : ~VS_POL;
      display_on <= dly.de;
    end
  end
endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 800x600 @ 56 Hz display, 36 MHz pixel clock. It drives the `h_coord`/`v_coord` scan position consumed by the game plane and takes back that plane's 4-bit RGB. It outputs blanked, registered RGB plus HSYNC/VSYNC, aligned to the pixel that produced them. It sits between the game plane and the VGA pins.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 24: horizontal front porch
- `H_SYNC`, 72: hsync width
- `H_BP`, 128: horizontal back porch
- `V_ACTIVE`, 600: visible lines
- `V_FP`, 1: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BP`, 22: vertical back porch
- `HS_POL`, 1: hsync active level
- `VS_POL`, 1: vsync active level
- `RGB_LATENCY`, 0: cycles from coordinate to valid `red/green/blue`; legal range 0..3

Ports:
- `pixel_clk` in 1: pixel clock, 36 MHz.
- `rst_n` in 1: reset, asynchronous, active-low; single clock domain.
- `h_coord` out 11: horizontal counter, 0..H_TOTAL-1 (H_TOTAL=1024).
- `v_coord` out 10: vertical counter, 0..V_TOTAL-1 (V_TOTAL=625).
- `frame_start` out 1: one-cycle pulse while `h_coord`=0 and `v_coord`=0.
- `red`, `green`, `blue` in 4 each: pixel colour for the coordinate issued RGB_LATENCY cycles earlier.
- `vga_r`, `vga_g`, `vga_b` out 4 each: registered, blanked colour.
- `vga_hs`, `vga_vs` out 1 each: registered sync signals.
- `display_on` out 1: registered active-video flag, aligned with `vga_*`.

## Operation
- `h_coord` increments by 1 every cycle and wraps from H_TOTAL-1 to 0.
- `v_coord` increments only when `h_coord` wraps, and wraps from V_TOTAL-1 to 0 at the same edge.
- The counters keep running through blanking. The counter width is fixed and never saturates.
- Raw stage-0 flags, decoded from the counters:
  - de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [824,896)
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. [601,603)
- de, hs and vs pass through a shift register of depth RGB_LATENCY. Depth 0 is a straight wire.
- Output register stage:
  - `vga_r/g/b` = delayed de ? `red/green/blue` : 0
  - `vga_hs` = delayed hs ? HS_POL : !HS_POL; `vga_vs` is formed the same way with VS_POL.
  - `display_on` = delayed de.
- Timing totals are derived parameters: H_TOTAL = sum of the H_* parameters, V_TOTAL = sum of the V_* parameters. Counter widths stay 11/10 bits, so H_TOTAL ≤ 2048 and V_TOTAL ≤ 1024. This is checked by an elaboration assertion.
- Reset (async assert, sync release through the normal clock edge):
  - counters = 0, `frame_start` = 0, `vga_r/g/b` = 0, `display_on` = 0
  - `vga_hs` = !HS_POL, `vga_vs` = !VS_POL
  - all delay-stage flags clear: de=0, hs/vs inactive
- Reset mid-frame takes effect immediately, with no glitch to the active sync level. After release the frame restarts at (0,0). No partial sync pulse appears, because the delay stages are cleared.
- `frame_start` derives combinationally from registered counters, so it is glitch-free. It coincides with the pixel (0,0) the game plane evaluates.

## Timing
- Coordinate (h,v) is presented at cycle t.
- The colour for (h,v) is sampled at t+RGB_LATENCY.
- `vga_*`, `vga_hs`, `vga_vs` and `display_on` for (h,v) are valid from t+RGB_LATENCY+1.
- Line period is 1024 cycles and frame period is 640 000 cycles, i.e. 56.25 Hz at 36 MHz.
- hsync pulse is 72 cycles; vsync pulse is 2 lines (2048 cycles).
- The first clock after reset release shows `h_coord`=0, `v_coord`=0 and `frame_start`=1.

## Structure
- Shared package `vga_timing_pkg` holds:
  - localparams for the 800x600@56 defaults
  - derived H_TOTAL/V_TOTAL
  - typedefs `h_coord_t` (logic[10:0]), `v_coord_t` (logic[9:0]) and `rgb4_t` (logic[3:0])
- One sub-module, `vga_sync_delay`: parametric-depth shift register (WIDTH, DEPTH, RESET_VAL) with async active-low reset. It is instantiated once for the {de,hs,vs} bundle.

## Test plan
- Reset: assert `rst_n`=0 at an arbitrary time → outputs immediately show `vga_rgb`=0, `vga_hs`=`vga_vs`=0 (POL=1) and `display_on`=0. After release, first cycle shows coords (0,0) and `frame_start`=1.
- Horizontal timing: count cycles over 3 lines → `vga_hs` high exactly 72 cycles, starting at output of h=824, with a period of 1024 cycles.
- Vertical timing: run 2 frames → `vga_vs` high exactly 2048 cycles, starting at line 601. `frame_start` pulses every 640 000 cycles, one cycle wide.
- Blanking: drive `red`/`green`/`blue`=4'hF constantly → `vga_rgb`=F only while `display_on`. Check 480 000 active pixels per frame and 0 at h=800..1023 and at v=600..624.
- Latency: set RGB_LATENCY=1 and a model returning `red`=h[3:0] one cycle late → `vga_r` equals the h[3:0] of the `display_on` pixel. Repeat with RGB_LATENCY=0 and 3.
- Mid-frame reset: pulse `rst_n` low for 5 cycles at h=850, v=300 (inside hsync) → `vga_hs` drops asynchronously. No hs pulse occurs until h=824 of line 0 after release.
